// File: rtl/fc_layer_if.sv
// Streaming and configuration bundle for fc_layer_seq.
// master drives configuration, input elements and output back-pressure;
// slave (the layer) drives input ready and the serialised neuron outputs.
interface fc_layer_if #(
    parameter int DW = 16,
    parameter int AW = 4,
    parameter int IW = 2
);
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully-connected layer: one input element per beat updates
// all N_OUT accumulators, then the biased, saturated, ReLU'd results are
// drained one neuron per beat. Weights/biases live in a flat register file:
// weight(j,i) at j*N_IN+i, bias(j) at N_OUT*N_IN+j.
module fc_layer_seq #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 10,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    fc_layer_if.slave   bus
);
    localparam int DEPTH  = N_OUT * (N_IN + 1);
    localparam int AW     = $clog2(DEPTH);
    localparam int IW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CW     = $clog2(N_IN);
    localparam int BASE_B = N_OUT * N_IN;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [DW-1:0]            r_cfg [DEPTH];
    logic signed [ACC_W-1:0]  r_acc [N_OUT];
    logic signed [ACC_W-1:0]  w_acc_nxt [N_OUT];
    logic signed [2*DW-1:0]   w_prod [N_OUT];
    logic [CW-1:0]            r_in_cnt;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic [DW-1:0]            r_out_data;
    logic [IW-1:0]            r_out_idx;
    logic [IW-1:0]            w_idx_inc;
    logic                     w_accept;
    logic                     w_last_in;
    logic                     w_xfer;
    logic                     w_xfer_last;
    logic                     w_cfg_wr;

    // Arithmetic shift back to Q format, clamp to DW signed range, drop negatives.
    function automatic logic [DW-1:0] relu_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC;
        if (s[ACC_W-1]) begin
            relu_sat = {DW{1'b0}};
        end else if (s > SAT_MAX) begin
            relu_sat = SAT_MAX[DW-1:0];
        end else begin
            relu_sat = s[DW-1:0];
        end
    endfunction

    // clear blocks both handshakes so an element offered during abort is not consumed.
    assign w_accept    = bus.in_valid & r_in_ready & ~clear;
    assign w_last_in   = w_accept & (r_in_cnt == CW'(N_IN - 1));
    assign w_xfer      = r_out_valid & bus.out_ready & ~clear;
    assign w_xfer_last = w_xfer & r_out_last;
    assign w_idx_inc   = r_out_idx + IW'(1);
    assign w_cfg_wr    = bus.cfg_we & (r_state == S_IDLE) & ~clear &
                         ({1'b0, bus.cfg_addr} < (AW+1)'(DEPTH));

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;

    // Per-neuron product and next accumulator; element 0 seeds with the scaled bias.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            w_prod[j] = (2*DW)'($signed(bus.in_data)) *
                        (2*DW)'($signed(r_cfg[AW'(j * N_IN) + AW'(r_in_cnt)]));
            if (r_in_cnt == CW'(0)) begin
                w_acc_nxt[j] = (ACC_W'($signed(r_cfg[AW'(BASE_B + j)])) <<< FRAC) +
                               ACC_W'(w_prod[j]);
            end else begin
                w_acc_nxt[j] = r_acc[j] + ACC_W'(w_prod[j]);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; clear overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = S_ACCUM;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ACCUM: begin
                    if (w_last_in) begin
                        w_state_nxt = S_OUTPUT;
                    end else begin
                        w_state_nxt = S_ACCUM;
                    end
                end
                S_OUTPUT: begin
                    if (w_xfer_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_OUTPUT;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Config storage, accumulators, counters and registered output port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_cfg[k] <= {DW{1'b0}};
            end
            for (int j = 0; j < N_OUT; j++) begin
                r_acc[j] <= {ACC_W{1'b0}};
            end
            r_in_cnt    <= CW'(0);
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= {DW{1'b0}};
            r_out_idx   <= IW'(0);
        end else begin
            if (w_cfg_wr) begin
                r_cfg[bus.cfg_addr] <= bus.cfg_data;
            end
            if (w_accept) begin
                for (int j = 0; j < N_OUT; j++) begin
                    r_acc[j] <= w_acc_nxt[j];
                end
            end
            r_in_ready  <= (w_state_nxt != S_OUTPUT);
            r_out_valid <= (w_state_nxt == S_OUTPUT);
            if (clear) begin
                r_in_cnt   <= CW'(0);
                r_out_idx  <= IW'(0);
                r_out_last <= 1'b0;
                r_out_data <= {DW{1'b0}};
            end else begin
                if (w_accept) begin
                    r_in_cnt <= w_last_in ? CW'(0) : r_in_cnt + CW'(1);
                end
                // The first result is taken from the freshly computed sum so it
                // is valid one cycle after the last input beat.
                if (w_last_in) begin
                    r_out_idx  <= IW'(0);
                    r_out_last <= (N_OUT == 1);
                    r_out_data <= relu_sat(w_acc_nxt[0]);
                end else if (w_xfer_last) begin
                    r_out_idx  <= IW'(0);
                    r_out_last <= 1'b0;
                    r_out_data <= {DW{1'b0}};
                end else if (w_xfer) begin
                    r_out_idx  <= w_idx_inc;
                    r_out_last <= (w_idx_inc == IW'(N_OUT - 1));
                    r_out_data <= relu_sat(r_acc[w_idx_inc]);
                end
            end
        end
    end
endmodule
